// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared types and constants for the instruction fetch controller.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_pkg;

   typedef enum logic [1:0] {
      PC_ADV        = 2'b00,
      PC_HOLD_MEM   = 2'b01,
      PC_HOLD_STALL = 2'b10,
      PC_RESTART    = 2'b11
   } pc_choice_e;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_e;

   localparam int FETCH_TIMEOUT_DEFAULT = 15;

   // Wide enough for the largest supported TIMEOUT of 15.
   localparam int c_WAIT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_ctrl_if
// Brief   : PC, instruction-memory and downstream signals of the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
   import riscv_pkg::*;

   logic [31:0] pc_in;
   pc_choice_e  pc_choice;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        fetch_err;

   modport master (
      input  pc_in, imem_ready, imem_rdata, stall, flush,
      output pc_choice, imem_req, imem_addr, instr_valid, instr_out, instr_pc, fetch_err
   );

   modport slave (
      output pc_in, imem_ready, imem_rdata, stall, flush,
      input  pc_choice, imem_req, imem_addr, instr_valid, instr_out, instr_pc, fetch_err
   );

endinterface
`default_nettype wire

// File: rtl/fetch_timeout.sv
`default_nettype none
// ============================================================================
// Module  : fetch_timeout
// Brief   : Counts consecutive unanswered fetch cycles and flags the timeout.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_timeout
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam logic [c_WAIT_CNT_W-1:0] c_LIMIT = c_WAIT_CNT_W'(TIMEOUT - 1);
   localparam logic [c_WAIT_CNT_W-1:0] c_ONE   = c_WAIT_CNT_W'(1);

   logic [c_WAIT_CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_count <= '0;
      end else if (count_en) begin
         r_count <= r_count + c_ONE;
      end
   end

   // Fires on the TIMEOUT-th unanswered cycle, not one cycle after it.
   assign expired = count_en && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fetch_ctrl
// Brief   : Single-slot instruction fetch controller with timeout restart.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   fetch_ctrl_if.master  bus
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   pc_choice_e   w_choice;

   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        r_err;

   logic w_req;
   logic w_hs;
   logic w_wait;
   logic w_timeout;
   logic w_restart;
   logic w_cnt_clear;

   // Gating with reset keeps a late memory response from being accepted.
   assign w_req       = !reset && (r_state == FETCH) && (!r_valid || !bus.stall);
   assign w_hs        = w_req && bus.imem_ready;
   assign w_wait      = w_req && !bus.imem_ready;
   assign w_restart   = bus.flush || w_timeout;
   assign w_cnt_clear = w_hs || bus.flush || (r_state == IDLE) || w_timeout;

   fetch_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .count_en (w_wait),
      .clear    (w_cnt_clear),
      .expired  (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_choice    = PC_HOLD_STALL;

      case (r_state)
         IDLE:    w_state_nxt = w_restart ? IDLE : FETCH;
         FETCH:   w_state_nxt = w_restart ? IDLE : FETCH;
         default: w_state_nxt = IDLE;
      endcase

      if (reset || w_restart) begin
         w_choice = PC_RESTART;
      end else if (w_hs) begin
         w_choice = PC_ADV;
      end else if (w_wait) begin
         w_choice = PC_HOLD_MEM;
      end
   end

   // Restart discards any same-cycle handshake; a handshake otherwise refills the slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (w_restart) begin
         r_valid <= 1'b0;
      end else if (w_hs) begin
         r_valid <= 1'b1;
         r_instr <= bus.imem_rdata;
         r_pc    <= bus.pc_in;
      end else if (r_valid && !bus.stall) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign bus.pc_choice   = w_choice;
   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = bus.pc_in;
   assign bus.instr_valid = r_valid;
   assign bus.instr_out   = r_instr;
   assign bus.instr_pc    = r_pc;
   assign bus.fetch_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_ctrl
// Brief   : Self-checking bench for fetch_ctrl with a behavioural fetch model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
   import riscv_pkg::*;

   localparam int TIMEOUT = FETCH_TIMEOUT_DEFAULT;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fetch_ctrl_if bus ();

   fetch_ctrl #(
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: slot contents, FETCH/IDLE flag, wait count, PC register.
   bit          m_fetch = 1'b0;
   bit          m_valid = 1'b0;
   bit          m_err   = 1'b0;
   logic [31:0] m_out   = '0;
   logic [31:0] m_pc    = '0;
   logic [31:0] m_pcreg = '0;
   int          m_wait  = 0;

   // PC register of the environment, driven by the DUT's own pc_choice.
   logic [31:0] tb_pc   = '0;
   logic [1:0]  d_choice;

   bit          cur_r, cur_rdy, cur_st, cur_fl;
   bit          e_req, e_hs, e_to;
   logic [1:0]  e_choice;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   task automatic apply(input bit r, input bit rdy, input bit st, input bit fl);
      @(negedge clk);
      cur_r = r; cur_rdy = rdy; cur_st = st; cur_fl = fl;
      reset          = r;
      bus.imem_ready = rdy;
      bus.stall      = st;
      bus.flush      = fl;
      bus.pc_in      = tb_pc;
      bus.imem_rdata = memf(tb_pc);
      #1;
      e_req = !r && m_fetch && (!m_valid || !st);
      e_hs  = e_req && rdy;
      e_to  = e_req && !rdy && (m_wait == TIMEOUT - 1);
      if (r || fl || e_to)  e_choice = 2'b11;
      else if (e_hs)        e_choice = 2'b00;
      else if (e_req)       e_choice = 2'b01;
      else                  e_choice = 2'b10;
      d_choice = bus.pc_choice;
   endtask

   task automatic step();
      @(posedge clk);
      if (cur_r) begin
         m_fetch = 0; m_valid = 0; m_err = 0; m_out = '0; m_pc = '0; m_wait = 0;
      end else if (cur_fl || e_to) begin
         m_valid = 0; m_fetch = 0; m_wait = 0;
         if (e_to) m_err = 1;
      end else begin
         if (e_hs) begin
            m_valid = 1; m_out = memf(m_pcreg); m_pc = m_pcreg;
         end else if (m_valid && !cur_st) begin
            m_valid = 0;
         end
         if (e_hs || !m_fetch)       m_wait = 0;
         else if (e_req && !cur_rdy) m_wait = m_wait + 1;
         m_fetch = 1;
      end
      case (e_choice)
         2'b00:   m_pcreg = m_pcreg + 1;
         2'b11:   m_pcreg = '0;
         default: m_pcreg = m_pcreg;
      endcase
      case (d_choice)
         2'b00:   tb_pc = tb_pc + 1;
         2'b11:   tb_pc = '0;
         default: tb_pc = tb_pc;
      endcase
   endtask

   task automatic do_reset();
      apply(1, 0, 0, 0); step();
      apply(1, 0, 0, 0); step();
   endtask

   task automatic run_until(input logic [31:0] target);
      for (int n = 0; n < 64 && tb_pc != target; n++) begin
         apply(0, 1, 0, 0); step();
      end
      checks++;
      if (tb_pc !== target) begin
         errors++; $display("FAIL run_until: pc_in=%0d required=%0d", tb_pc, target);
      end
   endtask

   task automatic test_reset();
      apply(1, 1, 0, 1);
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
      checks++; if (bus.pc_choice !== 2'b11) begin errors++; $display("FAIL reset_choice: got %b want 11", bus.pc_choice); end
      step();
      apply(1, 1, 0, 0);
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
      checks++; if (bus.instr_out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", bus.instr_out); end
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.instr_pc); end
      checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.fetch_err); end
      checks++; if (bus.pc_choice !== 2'b11) begin errors++; $display("FAIL reset_choice2: got %b want 11", bus.pc_choice); end
      step();
   endtask

   task automatic test_stream();
      apply(0, 1, 0, 0);
      checks++; if (bus.pc_choice !== 2'b10) begin errors++; $display("FAIL stream_idle: got %b want 10", bus.pc_choice); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stream_idle_req: got %b want 0", bus.imem_req); end
      step();
      for (int i = 0; i < 6; i++) begin
         apply(0, 1, 0, 0);
         checks++; if (bus.pc_choice !== 2'b00) begin errors++; $display("FAIL stream_choice[%0d]: got %b want 00", i, bus.pc_choice); end
         checks++; if (bus.imem_addr !== 32'(i)) begin errors++; $display("FAIL stream_addr[%0d]: got %0d want %0d", i, bus.imem_addr, i); end
         if (i > 0) begin
            checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.instr_valid); end
            checks++; if (bus.instr_pc !== 32'(i - 1)) begin errors++; $display("FAIL stream_pc[%0d]: got %0d want %0d", i, bus.instr_pc, i - 1); end
            checks++; if (bus.instr_out !== memf(32'(i - 1))) begin errors++; $display("FAIL stream_out[%0d]: got %h want %h", i, bus.instr_out, memf(32'(i - 1))); end
         end
         step();
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      run_until(5);
      for (int k = 0; k < 3; k++) begin
         apply(0, 0, 0, 0);
         checks++; if (bus.pc_choice !== 2'b01) begin errors++; $display("FAIL wait_choice[%0d]: got %b want 01", k, bus.pc_choice); end
         checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", k, bus.imem_req); end
         step();
      end
      apply(0, 1, 0, 0);
      checks++; if (bus.pc_choice !== 2'b00) begin errors++; $display("FAIL wait_adv: got %b want 00", bus.pc_choice); end
      step();
      apply(0, 1, 0, 0);
      checks++; if (bus.instr_out !== memf(5)) begin errors++; $display("FAIL wait_out: got %h want %h", bus.instr_out, memf(5)); end
      checks++; if (bus.instr_pc !== 32'd5) begin errors++; $display("FAIL wait_pc: got %0d want 5", bus.instr_pc); end
      checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL wait_err: got %b want 0", bus.fetch_err); end
      step();
   endtask

   task automatic test_stall();
      run_until(7);
      apply(0, 1, 0, 0); step();
      for (int k = 0; k < 4; k++) begin
         apply(0, 1, 1, 0);
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", k, bus.imem_req); end
         checks++; if (bus.pc_choice !== 2'b10) begin errors++; $display("FAIL stall_choice[%0d]: got %b want 10", k, bus.pc_choice); end
         checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.instr_valid); end
         checks++; if (bus.instr_pc !== 32'd7) begin errors++; $display("FAIL stall_pc[%0d]: got %0d want 7", k, bus.instr_pc); end
         checks++; if (bus.instr_out !== memf(7)) begin errors++; $display("FAIL stall_out[%0d]: got %h want %h", k, bus.instr_out, memf(7)); end
         step();
      end
      apply(0, 1, 0, 0);
      checks++; if (bus.pc_choice !== 2'b00) begin errors++; $display("FAIL stall_release: got %b want 00", bus.pc_choice); end
      checks++; if (bus.imem_addr !== 32'd8) begin errors++; $display("FAIL stall_addr: got %0d want 8", bus.imem_addr); end
      step();
      apply(0, 1, 0, 0);
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %b want 1", bus.instr_valid); end
      checks++; if (bus.instr_pc !== 32'd8) begin errors++; $display("FAIL stall_next_pc: got %0d want 8", bus.instr_pc); end
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      run_until(3);
      for (int k = 1; k <= TIMEOUT; k++) begin
         apply(0, 0, 0, 0);
         checks++;
         if (bus.pc_choice !== ((k == TIMEOUT) ? 2'b11 : 2'b01)) begin
            errors++; $display("FAIL timeout_choice[%0d]: got %b want %b", k, bus.pc_choice, (k == TIMEOUT) ? 2'b11 : 2'b01);
         end
         step();
      end
      apply(0, 1, 0, 0);
      checks++; if (bus.fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", bus.fetch_err); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b want 0", bus.instr_valid); end
      checks++; if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL timeout_addr: got %0d want 0", bus.imem_addr); end
      step();
      apply(0, 1, 0, 0); step();
      apply(0, 1, 0, 0);
      checks++; if (bus.instr_pc !== 32'd0 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL timeout_resume: got pc=%0d valid=%b want pc=0 valid=1", bus.instr_pc, bus.instr_valid); end
      step();
   endtask

   task automatic test_flush();
      run_until(9);
      apply(0, 1, 0, 1);
      checks++; if (bus.pc_choice !== 2'b11) begin errors++; $display("FAIL flush_choice: got %b want 11", bus.pc_choice); end
      step();
      apply(0, 1, 0, 0);
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.instr_valid); end
      checks++; if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL flush_addr: got %0d want 0", bus.imem_addr); end
      checks++; if (bus.fetch_err !== 1'b1) begin errors++; $display("FAIL flush_err_sticky: got %b want 1", bus.fetch_err); end
      step();
      apply(0, 1, 0, 0); step();
      apply(0, 1, 0, 0);
      checks++; if (bus.instr_pc !== 32'd0 || bus.instr_out !== memf(0)) begin errors++; $display("FAIL flush_first: got pc=%0d out=%h want pc=0 out=%h", bus.instr_pc, bus.instr_out, memf(0)); end
      step();
   endtask

   task automatic test_reset_mid_wait();
      run_until(4);
      apply(0, 0, 0, 0); step();
      apply(0, 0, 0, 0); step();
      apply(1, 1, 0, 0);
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmw_req: got %b want 0", bus.imem_req); end
      checks++; if (bus.pc_choice !== 2'b11) begin errors++; $display("FAIL rmw_choice: got %b want 11", bus.pc_choice); end
      step();
      apply(0, 1, 0, 0);
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid: got %b want 0", bus.instr_valid); end
      checks++; if (bus.instr_out !== 32'h0 || bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rmw_slot: got out=%h pc=%h want 0", bus.instr_out, bus.instr_pc); end
      checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL rmw_err: got %b want 0", bus.fetch_err); end
      checks++; if (bus.pc_choice !== 2'b10) begin errors++; $display("FAIL rmw_idle: got %b want 10", bus.pc_choice); end
      step();
      apply(0, 1, 0, 0); step();
      apply(0, 1, 0, 0);
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'd0) begin errors++; $display("FAIL rmw_restart: got valid=%b pc=%0d want 1/0", bus.instr_valid, bus.instr_pc); end
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         apply(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 4) == 0, ($urandom % 40) == 0);
         checks++; if (bus.imem_req !== e_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", n, bus.imem_req, e_req); end
         checks++; if (bus.pc_choice !== e_choice) begin errors++; $display("FAIL rnd_choice[%0d]: got %b want %b", n, bus.pc_choice, e_choice); end
         checks++; if (bus.imem_addr !== m_pcreg) begin errors++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", n, bus.imem_addr, m_pcreg); end
         checks++; if (bus.instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.instr_valid, m_valid); end
         checks++; if (bus.instr_out !== m_out) begin errors++; $display("FAIL rnd_out[%0d]: got %h want %h", n, bus.instr_out, m_out); end
         checks++; if (bus.instr_pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %0d want %0d", n, bus.instr_pc, m_pc); end
         checks++; if (bus.fetch_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, bus.fetch_err, m_err); end
         step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.pc_in      = '0;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      bus.stall      = 1'b0;
      bus.flush      = 1'b0;
      test_reset();
      test_stream();
      test_mem_wait();
      test_stall();
      test_timeout();
      test_flush();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, number of consecutive unanswered request cycles before a timeout restart (range 2..15).
REQ-002 The interface SHALL include: clk  in  1  clock; all state changes on its rising edge.
REQ-003 The interface SHALL include: reset  in  1  synchronous, active-high reset.
REQ-004 The interface SHALL include: pc_in  in  32  current PC value, as a word index.
REQ-005 The interface SHALL include: pc_choice  out  2  PC control: 00 advance, 01 hold (memory wait), 10 hold (stall/idle), 11 restart to 0.
REQ-006 The interface SHALL include: imem_req  out  1  instruction fetch request.
REQ-007 The interface SHALL include: imem_addr  out  32  fetch address, always equal to pc_in.
REQ-008 The interface SHALL include: imem_ready  in  1  memory response; imem_rdata is valid in any cycle where imem_req && imem_ready.
REQ-009 The interface SHALL include: imem_rdata  in  32  instruction word.
REQ-010 The interface SHALL include: stall  in  1  downstream cannot accept the held instruction this cycle.
REQ-011 The interface SHALL include: flush  in  1  discard the held instruction and restart fetch at PC 0.
REQ-012 The interface SHALL include: instr_valid  out  1  instr_out and instr_pc hold a valid instruction.
REQ-013 The interface SHALL include: instr_out  out  32  fetched instruction.
REQ-014 The interface SHALL include: instr_pc  out  32  PC of instr_out.
REQ-015 The interface SHALL include: fetch_err  out  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE and FETCH; IDLE SHALL last exactly one cycle and then go to FETCH.
REQ-017 imem_req SHALL equal (state==FETCH) && (!instr_valid || !stall), combinationally.
REQ-018 A handshake (imem_req && imem_ready) SHALL load instr_out <= imem_rdata, instr_pc <= pc_in and instr_valid <= 1 at the next edge.
REQ-019 The slot SHALL be consumed when instr_valid && !stall; on consumption with no handshake, instr_valid <= 0.
REQ-020 pc_choice SHALL be resolved combinationally in priority order: flush or timeout -> 11; handshake -> 00; imem_req && !imem_ready -> 01; otherwise -> 10.
REQ-021 A wait counter SHALL increment on each cycle with imem_req && !imem_ready and clear on handshake, flush or IDLE; stall cycles SHALL neither increment nor clear it.
REQ-022 Timeout SHALL fire in the cycle where the counter equals TIMEOUT-1 and imem_req && !imem_ready hold; this gives the (TIMEOUT)th consecutive unanswered cycle.
REQ-023 On flush or timeout: instr_valid <= 0, state <= IDLE, wait counter <= 0, and any handshake in the same cycle SHALL be discarded.
REQ-024 Timeout SHALL set fetch_err <= 1; fetch_err SHALL stay set until reset, and flush SHALL NOT clear it.
REQ-025 Steady-state throughput SHALL be one instruction per cycle when imem_ready=1 and stall=0, with fetch latency of 1 cycle from handshake to instr_valid.
REQ-026 Back-to-back operation: a handshake in the same cycle as consumption SHALL replace the slot with no bubble.
REQ-027 While stalled, instr_out, instr_pc and instr_valid SHALL be held unchanged.

Reset
REQ-028 While reset=1, the outputs SHALL be: state=IDLE, instr_valid=0, instr_out=0, instr_pc=0, fetch_err=0, wait counter=0, imem_req=0, pc_choice=11.
REQ-029 Reset SHALL take priority over flush, timeout and handshake.
REQ-030 Reset asserted mid-wait SHALL abandon the outstanding request, and a late imem_ready SHALL be ignored.

Structure
REQ-031 Package riscv_pkg SHALL hold the enum pc_choice_e (PC_ADV=00, PC_HOLD_MEM=01, PC_HOLD_STALL=10, PC_RESTART=11), the enum fetch_state_e (IDLE, FETCH) and the constant FETCH_TIMEOUT_DEFAULT=15.
REQ-032 The wait counter and timeout compare SHALL be the single sub-module fetch_timeout (ports: clk, reset, count_en, clear, expired).

Verification
REQ-033 Scenario: reset, then imem_ready=1 and stall=0 continuously, with pc_in driven by the PC -> pc_choice 10,00,00,...; instr_pc sequence 0,1,2,3 with instr_valid=1 from cycle 3.
REQ-034 Scenario: imem_ready low for 3 cycles at PC=5 -> pc_choice=01 for 3 cycles then 00; instr_out=rdata at PC 5; fetch_err=0.
REQ-035 Scenario: stall=1 for 4 cycles with a held instruction at PC=7 -> imem_req=0, pc_choice=10, instr_out and instr_pc=7 stable; on release the next instruction (PC 8) follows with no bubble.
REQ-036 Scenario: imem_ready=0 for 15 cycles with TIMEOUT=15 -> pc_choice=11 on the 15th cycle, fetch_err=1 thereafter, instr_valid=0, fetch resumes at PC 0.
REQ-037 Scenario: flush coinciding with a handshake at PC=9 -> instr_valid=0 next cycle, pc_choice=11, PC 9 data dropped, first new instr_pc=0.
REQ-038 Scenario: reset asserted mid-wait, with imem_ready rising in the reset cycle -> no instr_valid, all outputs at their reset values, normal restart afterwards.
